// File: rtl/traffic_pkg.sv
// Shared definitions for the four-way traffic controller: lamp encodings,
// controller state encodings and direction bit positions.
package traffic_pkg;

    // Lamp encodings for a 3-bit {red, yellow, green} signal head
    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    // Bit positions of each approach in arrow and mask vectors
    localparam int DIR_N = 0;
    localparam int DIR_S = 1;
    localparam int DIR_E = 2;
    localparam int DIR_W = 3;

    // Normal-operation states; the numeric value is what the phase port shows
    typedef enum logic [3:0] {
        NS_GRN   = 4'd0,
        NS_SPLIT = 4'd1,
        N_PROT   = 4'd2,
        N_YEL    = 4'd3,
        S_PROT   = 4'd4,
        S_YEL    = 4'd5,
        CLR_NS   = 4'd6,
        EW_GRN   = 4'd7,
        EW_SPLIT = 4'd8,
        E_PROT   = 4'd9,
        E_YEL    = 4'd10,
        W_PROT   = 4'd11,
        W_YEL    = 4'd12,
        CLR_EW   = 4'd13,
        PED      = 4'd14,
        FLASH    = 4'd15
    } state_t;

    // Emergency sub-states, only meaningful while the preempt flag is set
    typedef enum logic [1:0] {
        EM_YEL  = 2'd0,
        EM_HOLD = 2'd1,
        EM_CLR  = 2'd2
    } em_state_t;

    // True for the single-direction yellow states that end a green group
    function automatic logic is_yellow(input state_t s);
        return (s == N_YEL) || (s == S_YEL) || (s == E_YEL) || (s == W_YEL);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counting phase timer: loads a value, counts toward zero and holds
// there; done is high while the count reads zero.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    // Load takes priority; otherwise decrement and saturate at zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/traffic_ctrl_param.sv
// Four-way intersection controller with protected turn phases, pedestrian
// service, night flash and emergency preemption. Lamp outputs are decoded
// from registered state and forced to all-red while reset is asserted.
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int T_GREEN = 10,
    parameter int T_PROT  = 5,
    parameter int T_YEL   = 2,
    parameter int T_CLR   = 2,
    parameter int T_PED   = 8,
    parameter int T_FLASH = 4,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_req,
    input  logic       emerg,
    input  logic       flash_en,
    output logic [2:0] n_light,
    output logic [2:0] s_light,
    output logic [2:0] e_light,
    output logic [2:0] w_light,
    output logic [3:0] left_arrow,
    output logic [3:0] right_arrow,
    output logic       ped_walk,
    output logic       preempt_active,
    output logic [3:0] phase
);

    state_t     state_reg, state_next;
    em_state_t  em_reg, em_next;
    logic       preempt_reg, preempt_next;
    logic [3:0] mask_reg, mask_next;
    logic       flash_dark_reg, flash_dark_next;
    logic       ped_pending_reg, ped_pending_next;
    logic       go_ns_reg, go_ns_next;   // where a clearance leads next

    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] count;
    logic             done;

    logic [2:0] lt [4];
    logic [2:0] light_out [4];
    logic [3:0] la, ra;
    logic       walk;
    logic [3:0] grn_mask, yel_mask;
    logic       ew;
    logic [3:0] base;
    logic [1:0] a, b;

    // Duration minus one for each state, as loaded into the timer on entry
    function automatic logic [CNT_W-1:0] dur(input state_t s);
        case (s)
            NS_GRN, EW_GRN:                    dur = CNT_W'(T_GREEN - 1);
            N_PROT, S_PROT, E_PROT, W_PROT:    dur = CNT_W'(T_PROT - 1);
            CLR_NS, CLR_EW:                    dur = CNT_W'(T_CLR - 1);
            PED:                               dur = CNT_W'(T_PED - 1);
            FLASH:                             dur = CNT_W'(T_FLASH - 1);
            default:                           dur = CNT_W'(T_YEL - 1);
        endcase
    endfunction

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(T_GREEN - 1))
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .done     (done)
    );

    // Lamp decode of the registered state; E/W states reuse the N/S pattern
    // with E in N's role and W in S's role
    always_comb begin
        for (int i = 0; i < 4; i++) lt[i] = RED;
        la   = '0;
        ra   = '0;
        walk = 1'b0;
        ew   = (state_reg >= EW_GRN) && (state_reg <= W_YEL);
        base = ew ? (4'(state_reg) - 4'd7) : 4'(state_reg);
        a    = ew ? 2'(DIR_E) : 2'(DIR_N);
        b    = ew ? 2'(DIR_W) : 2'(DIR_S);
        if (preempt_reg) begin
            if (em_reg == EM_YEL) begin
                for (int i = 0; i < 4; i++) lt[i] = mask_reg[i] ? YEL : RED;
            end
        end else begin
            case (state_reg)
                PED:            walk = 1'b1;
                FLASH:          for (int i = 0; i < 4; i++) lt[i] = flash_dark_reg ? DARK : RED;
                CLR_NS, CLR_EW: ;
                default: begin
                    case (base)
                        4'd0: begin lt[a] = GRN; lt[b] = GRN; la[a] = 1'b1; la[b] = 1'b1; end
                        4'd1: begin lt[a] = GRN; lt[b] = YEL; la[a] = 1'b1; end
                        4'd2: begin lt[a] = GRN; la[a] = 1'b1; ra[a] = 1'b1; end
                        4'd3: lt[a] = YEL;
                        4'd4: begin lt[b] = GRN; la[b] = 1'b1; ra[b] = 1'b1; end
                        4'd5: lt[b] = YEL;
                        default: ;
                    endcase
                end
            endcase
        end
    end

    // Per-direction green/yellow masks and reset gating of the lamps
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dir
            assign grn_mask[gi]  = (lt[gi] == GRN);
            assign yel_mask[gi]  = (lt[gi] == YEL);
            assign light_out[gi] = reset ? RED : lt[gi];
        end
    endgenerate

    assign n_light        = light_out[DIR_N];
    assign s_light        = light_out[DIR_S];
    assign e_light        = light_out[DIR_E];
    assign w_light        = light_out[DIR_W];
    assign left_arrow     = reset ? 4'b0000 : la;
    assign right_arrow    = reset ? 4'b0000 : ra;
    assign ped_walk       = walk & ~reset;
    assign preempt_active = preempt_reg & ~reset;
    assign phase          = preempt_reg ? 4'(CLR_NS) : 4'(state_reg);

    // Next-state logic: emergency first, then timed transitions
    always_comb begin
        state_next       = state_reg;
        em_next          = em_reg;
        preempt_next     = preempt_reg;
        mask_next        = mask_reg;
        flash_dark_next  = flash_dark_reg;
        go_ns_next       = go_ns_reg;
        ped_pending_next = ped_pending_reg | ped_req;
        load             = 1'b0;
        load_val         = dur(state_reg);
        if (preempt_reg) begin
            case (em_reg)
                EM_YEL: begin
                    // emerg dropping here is ignored; HOLD is always visited
                    if (done) em_next = EM_HOLD;
                end
                EM_HOLD: begin
                    if (!emerg) begin
                        em_next  = EM_CLR;
                        load     = 1'b1;
                        load_val = CNT_W'(T_CLR - 1);
                    end
                end
                default: begin
                    if (emerg) begin
                        em_next = EM_HOLD;
                    end else if (done) begin
                        preempt_next = 1'b0;
                        mask_next    = '0;
                        state_next   = NS_GRN;
                        load         = 1'b1;
                        load_val     = dur(NS_GRN);
                    end
                end
            endcase
        end else if (emerg) begin
            preempt_next = 1'b1;
            if (|grn_mask) begin
                em_next   = EM_YEL;
                mask_next = grn_mask;
                load      = 1'b1;
                load_val  = CNT_W'(T_YEL - 1);
            end else if (is_yellow(state_reg) && !done) begin
                // keep counting down so the yellow keeps its full length
                em_next   = EM_YEL;
                mask_next = yel_mask;
            end else begin
                em_next = EM_HOLD;
            end
        end else if (done) begin
            load = 1'b1;
            case (state_reg)
                CLR_NS, CLR_EW: begin
                    if (flash_en) begin
                        state_next      = FLASH;
                        flash_dark_next = 1'b0;
                    end else if (ped_pending_reg) begin
                        state_next       = PED;
                        ped_pending_next = ped_req;
                    end else begin
                        state_next = go_ns_reg ? NS_GRN : EW_GRN;
                    end
                end
                PED: state_next = go_ns_reg ? NS_GRN : EW_GRN;
                FLASH: begin
                    if (flash_en) begin
                        flash_dark_next = ~flash_dark_reg;
                    end else begin
                        state_next = CLR_NS;
                        go_ns_next = 1'b1;
                    end
                end
                default: begin
                    state_next = state_t'(4'(state_reg) + 4'd1);
                    if (state_reg == S_YEL) go_ns_next = 1'b0;
                    if (state_reg == W_YEL) go_ns_next = 1'b1;
                end
            endcase
            load_val = dur(state_next);
        end
    end

    // Controller state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= NS_GRN;
            em_reg          <= EM_YEL;
            preempt_reg     <= 1'b0;
            mask_reg        <= '0;
            flash_dark_reg  <= 1'b0;
            ped_pending_reg <= 1'b0;
            go_ns_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            em_reg          <= em_next;
            preempt_reg     <= preempt_next;
            mask_reg        <= mask_next;
            flash_dark_reg  <= flash_dark_next;
            ped_pending_reg <= ped_pending_next;
            go_ns_reg       <= go_ns_next;
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param with default parameters: normal
// cycle, pedestrian service, emergency, flash, reset mid-PED and a random
// soak guarded by a cross-axis safety monitor.
module tb_traffic_ctrl_param;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ped_req = 1'b0;
    logic       emerg = 1'b0;
    logic       flash_en = 1'b0;
    logic [2:0] n_light, s_light, e_light, w_light;
    logic [3:0] left_arrow, right_arrow, phase;
    logic       ped_walk, preempt_active;

    int compared   = 0;
    int mismatched = 0;
    int cyc_n      = 0;

    logic [11:0] exp_lt [14];
    logic [3:0]  exp_la [14];
    logic [3:0]  exp_ra [14];
    int          dur_tab [14];

    localparam logic [11:0] ALL_RED  = {RED, RED, RED, RED};
    localparam logic [11:0] ALL_DARK = {DARK, DARK, DARK, DARK};
    localparam logic [11:0] EM_NS    = {YEL, YEL, RED, RED};

    wire [11:0] lights = {n_light, s_light, e_light, w_light};

    traffic_ctrl_param dut (
        .clk            (clk),
        .reset          (reset),
        .ped_req        (ped_req),
        .emerg          (emerg),
        .flash_en       (flash_en),
        .n_light        (n_light),
        .s_light        (s_light),
        .e_light        (e_light),
        .w_light        (w_light),
        .left_arrow     (left_arrow),
        .right_arrow    (right_arrow),
        .ped_walk       (ped_walk),
        .preempt_active (preempt_active),
        .phase          (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [11:0] elt, input logic [3:0] ela,
                           input logic [3:0] era, input logic ewalk, input logic epre);
        chk({tag, "_lights"}, 16'(lights), 16'(elt));
        chk({tag, "_left"}, 16'(left_arrow), 16'(ela));
        chk({tag, "_right"}, 16'(right_arrow), 16'(era));
        chk({tag, "_walk"}, 16'(ped_walk), 16'(ewalk));
        chk({tag, "_preempt"}, 16'(preempt_active), 16'(epre));
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
        cyc_n++;
    endtask

    // Assert reset asynchronously, check the forced outputs, release at a negedge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk_out("reset_async", ALL_RED, 4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("reset_phase", 16'(phase), 16'd0);
        ped_req  = 1'b0;
        emerg    = 1'b0;
        flash_en = 1'b0;
        @(negedge clk);
        chk_out("reset_held", ALL_RED, 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        cyc_n = 0;
        $display("[tb] reset released, cycle 0");
    endtask

    task automatic run_phase(input int p, input int n);
        $display("[tb] cycle %0d: expect phase %0d for %0d cycles", cyc_n, p, n);
        for (int i = 0; i < n; i++) begin
            chk("phase", 16'(phase), 16'(p));
            cyc();
        end
    endtask

    // One full normal state: outputs on entry, phase for its whole duration
    task automatic run_std(input int p);
        chk_out($sformatf("state%0d", p), exp_lt[p], exp_la[p], exp_ra[p], 1'b0, 1'b0);
        run_phase(p, dur_tab[p]);
    endtask

    // No cycle may show green or arrow on both axes
    always @(negedge clk) begin
        if (!reset) begin
            compared++;
            assert (!(((n_light == GRN) || (s_light == GRN) || (|left_arrow[1:0]) || (|right_arrow[1:0])) &&
                      ((e_light == GRN) || (w_light == GRN) || (|left_arrow[3:2]) || (|right_arrow[3:2]))))
            else begin
                mismatched++;
                $error("FAIL safety cycle=%0d lights=%0h left=%0h right=%0h", cyc_n, lights, left_arrow, right_arrow);
            end
        end
    end

    initial begin
        exp_lt[0]  = {GRN, GRN, RED, RED}; exp_la[0]  = 4'b0011; exp_ra[0]  = 4'b0000;
        exp_lt[1]  = {GRN, YEL, RED, RED}; exp_la[1]  = 4'b0001; exp_ra[1]  = 4'b0000;
        exp_lt[2]  = {GRN, RED, RED, RED}; exp_la[2]  = 4'b0001; exp_ra[2]  = 4'b0001;
        exp_lt[3]  = {YEL, RED, RED, RED}; exp_la[3]  = 4'b0000; exp_ra[3]  = 4'b0000;
        exp_lt[4]  = {RED, GRN, RED, RED}; exp_la[4]  = 4'b0010; exp_ra[4]  = 4'b0010;
        exp_lt[5]  = {RED, YEL, RED, RED}; exp_la[5]  = 4'b0000; exp_ra[5]  = 4'b0000;
        exp_lt[6]  = ALL_RED;              exp_la[6]  = 4'b0000; exp_ra[6]  = 4'b0000;
        exp_lt[7]  = {RED, RED, GRN, GRN}; exp_la[7]  = 4'b1100; exp_ra[7]  = 4'b0000;
        exp_lt[8]  = {RED, RED, GRN, YEL}; exp_la[8]  = 4'b0100; exp_ra[8]  = 4'b0000;
        exp_lt[9]  = {RED, RED, GRN, RED}; exp_la[9]  = 4'b0100; exp_ra[9]  = 4'b0100;
        exp_lt[10] = {RED, RED, YEL, RED}; exp_la[10] = 4'b0000; exp_ra[10] = 4'b0000;
        exp_lt[11] = {RED, RED, RED, GRN}; exp_la[11] = 4'b1000; exp_ra[11] = 4'b1000;
        exp_lt[12] = {RED, RED, RED, YEL}; exp_la[12] = 4'b0000; exp_ra[12] = 4'b0000;
        exp_lt[13] = ALL_RED;              exp_la[13] = 4'b0000; exp_ra[13] = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            dur_tab[7*k+0] = 10; dur_tab[7*k+1] = 2; dur_tab[7*k+2] = 5; dur_tab[7*k+3] = 2;
            dur_tab[7*k+4] = 5;  dur_tab[7*k+5] = 2; dur_tab[7*k+6] = 2;
        end

        #2;
        // Normal cycle: 56-cycle period through phases 0..13
        do_reset();
        for (int p = 0; p < 14; p++) run_std(p);
        chk("period_56", 16'(cyc_n), 16'd56);
        chk("period_wrap", 16'(phase), 16'd0);

        // Pedestrian pulse at cycle 3, served after CLR_NS, then EW_GRN
        do_reset();
        run_phase(0, 3);
        ped_req = 1'b1;
        run_phase(0, 1);
        ped_req = 1'b0;
        run_phase(0, 6);
        for (int p = 1; p < 7; p++) run_std(p);
        chk_out("ped_entry", ALL_RED, 4'b0000, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("ped_phase", 16'(phase), 16'd14);
            chk("ped_walk", 16'(ped_walk), 16'd1);
            cyc();
        end
        for (int p = 7; p < 14; p++) run_std(p);
        chk("ped_served_once", 16'(phase), 16'd0);

        // Reset mid-PED with a second request latched; pending must be cleared
        do_reset();
        ped_req = 1'b1;
        cyc();
        ped_req = 1'b0;
        run_phase(0, 9);
        for (int p = 1; p < 7; p++) run_std(p);
        run_phase(14, 2);
        ped_req = 1'b1;
        cyc();
        ped_req = 1'b0;
        chk("midped_walk", 16'(ped_walk), 16'd1);
        do_reset();
        for (int p = 0; p < 7; p++) run_std(p);
        chk("midped_no_pending", 16'(phase), 16'd7);

        // Emergency at cycle 4 in NS_GRN, held until cycle 10
        do_reset();
        run_phase(0, 4);
        emerg = 1'b1;
        run_phase(0, 1);
        for (int i = 0; i < 2; i++) begin
            chk_out("em_yel", EM_NS, 4'b0000, 4'b0000, 1'b0, 1'b1);
            chk("em_yel_phase", 16'(phase), 16'd6);
            cyc();
        end
        for (int i = 0; i < 6; i++) begin
            chk_out("em_red", ALL_RED, 4'b0000, 4'b0000, 1'b0, 1'b1);
            chk("em_red_phase", 16'(phase), 16'd6);
            if (i == 3) emerg = 1'b0;
            cyc();
        end
        chk("em_exit_cycle", 16'(cyc_n), 16'd13);
        run_std(0);
        chk("em_after_grn", 16'(phase), 16'd1);

        // One-cycle emergency pulse: yellow 2, hold 1, clear 2, then NS_GRN
        do_reset();
        run_phase(0, 4);
        emerg = 1'b1;
        run_phase(0, 1);
        emerg = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_out("empulse_yel", EM_NS, 4'b0000, 4'b0000, 1'b0, 1'b1);
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            chk_out("empulse_red", ALL_RED, 4'b0000, 4'b0000, 1'b0, 1'b1);
            cyc();
        end
        chk_out("empulse_back", exp_lt[0], exp_la[0], exp_ra[0], 1'b0, 1'b0);
        chk("empulse_phase", 16'(phase), 16'd0);

        // Flash: entered after CLR_NS, red/dark every 4 cycles, exit via CLR_NS
        do_reset();
        flash_en = 1'b1;
        for (int p = 0; p < 7; p++) run_std(p);
        for (int h = 0; h < 3; h++) begin
            for (int i = 0; i < 4; i++) begin
                if (h == 2 && i == 0) flash_en = 1'b0;
                chk("flash_phase", 16'(phase), 16'd15);
                chk_out($sformatf("flash_h%0d", h), (h % 2 == 1) ? ALL_DARK : ALL_RED,
                        4'b0000, 4'b0000, 1'b0, 1'b0);
                cyc();
            end
        end
        run_std(6);
        chk("flash_exit_ns", 16'(phase), 16'd0);

        // Random soak; the safety monitor checks every cycle
        do_reset();
        $display("[tb] random soak start");
        for (int i = 0; i < 3000; i++) begin
            ped_req = ($urandom_range(15) == 0);
            if ($urandom_range(63) == 0) emerg = ~emerg;
            if ($urandom_range(199) == 0) flash_en = ~flash_en;
            cyc();
        end
        ped_req  = 1'b0;
        emerg    = 1'b0;
        flash_en = 1'b0;
        $display("[tb] random soak done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
